// File: rtl/pipeline_control.sv
// Pipeline sequencer: merges stage stall requests, owns all PC redirects
// (branch, exception, ERET) and runs the post-exception flush window.
module pipeline_control #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] HANDLER_PC   = 32'h0000_0020
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_request_id,
  input  logic        stall_request_ex,
  input  logic        stall_request_mem,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        exception_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        register_pc_write_enable,
  output logic [31:0] register_pc_write_data,
  output logic [31:0] stall_cycle_count
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned PC_W  = 32;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  target_q, target_d;
  logic             pend_q, pend_d;
  logic [PC_W-1:0]  pend_target_q, pend_target_d;
  logic [PC_W-1:0]  count_q, count_d;
  logic [5:0]       stall_raw;

  // Deepest requester wins; a flush overrides every hold.
  always_comb begin
    stall_raw = 6'b000000;
    if (stall_request_mem)     stall_raw = 6'b011111;
    else if (stall_request_ex) stall_raw = 6'b001111;
    else if (stall_request_id) stall_raw = 6'b000111;
  end

  assign stall             = (state_q == FLUSH) ? 6'b000000 : stall_raw;
  assign flush             = (state_q == FLUSH);
  assign stall_cycle_count = count_q;

  always_comb begin
    state_d                  = state_q;
    cnt_d                    = cnt_q;
    target_d                 = target_q;
    pend_d                   = pend_q;
    pend_target_d            = pend_target_q;
    count_d                  = stall[0] ? count_q + 32'd1 : count_q;
    register_pc_write_enable = 1'b0;
    register_pc_write_data   = '0;
    unique case (state_q)
      RUN: begin
        if (exception_valid || eret_valid) begin
          // Trap entry drops any branch in this cycle and any pending redirect.
          target_d = exception_valid ? HANDLER_PC : epc;
          cnt_d    = CNT_W'(FLUSH_CYCLES);
          pend_d   = 1'b0;
          state_d  = FLUSH;
        end else if (!stall[0]) begin
          if (branch_valid) begin
            register_pc_write_enable = 1'b1;
            register_pc_write_data   = branch_target;
            pend_d                   = 1'b0;
          end else if (pend_q) begin
            register_pc_write_enable = 1'b1;
            register_pc_write_data   = pend_target_q;
            pend_d                   = 1'b0;
          end
        end else if (branch_valid) begin
          pend_d        = 1'b1;
          pend_target_d = branch_target;
        end
      end
      FLUSH: begin
        // The redirect is issued only in the first flush cycle.
        if (cnt_q == CNT_W'(FLUSH_CYCLES)) begin
          register_pc_write_enable = 1'b1;
          register_pc_write_data   = target_q;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      target_q      <= '0;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: stall merge, branch redirect and
// pending redirect, exception/ERET flush sequencing and asynchronous reset.
module tb_pipeline_control;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_request_id, stall_request_ex, stall_request_mem;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        exception_valid, eret_valid;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic        register_pc_write_enable;
  logic [31:0] register_pc_write_data;
  logic [31:0] stall_cycle_count;

  int total = 0;
  int bad   = 0;

  pipeline_control #(.FLUSH_CYCLES(2), .HANDLER_PC(32'h0000_0020)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .stall_request_id         (stall_request_id),
    .stall_request_ex         (stall_request_ex),
    .stall_request_mem        (stall_request_mem),
    .branch_valid             (branch_valid),
    .branch_target            (branch_target),
    .exception_valid          (exception_valid),
    .eret_valid               (eret_valid),
    .epc                      (epc),
    .stall                    (stall),
    .flush                    (flush),
    .register_pc_write_enable (register_pc_write_enable),
    .register_pc_write_data   (register_pc_write_data),
    .stall_cycle_count        (stall_cycle_count)
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    stall_request_id = 0; stall_request_ex = 0; stall_request_mem = 0;
    branch_valid = 0; branch_target = '0;
    exception_valid = 0; eret_valid = 0; epc = '0;
  endtask

  task automatic do_reset();
    cyc(); reset = 0; idle_inputs(); #1;
    cyc(); reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 0; #2;
    total++; if (stall !== 6'b0) begin bad++; $display("FAIL reset_stall got=%b exp=000000", stall); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
    total++; if (register_pc_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", register_pc_write_enable); end
    total++; if (register_pc_write_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", register_pc_write_data); end
    total++; if (stall_cycle_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", stall_cycle_count); end
    cyc(); reset = 1;
  endtask

  task automatic test_stall_merge();
    do_reset();
    cyc(); stall_request_ex = 1; #1;
    total++; if (stall !== 6'b001111) begin bad++; $display("FAIL merge_ex got=%b exp=001111", stall); end
    cyc(); stall_request_mem = 1; #1;
    total++; if (stall !== 6'b011111) begin bad++; $display("FAIL merge_mem_ex got=%b exp=011111", stall); end
    cyc(); stall_request_mem = 0; stall_request_ex = 0; stall_request_id = 1; #1;
    total++; if (stall !== 6'b000111) begin bad++; $display("FAIL merge_id got=%b exp=000111", stall); end
    cyc(); stall_request_id = 0; #1;
    total++; if (stall !== 6'b000000) begin bad++; $display("FAIL merge_none got=%b exp=000000", stall); end
    total++; if (stall_cycle_count !== 32'd3) begin bad++; $display("FAIL merge_count got=%0d exp=3", stall_cycle_count); end
    cyc(); #1;
    total++; if (stall_cycle_count !== 32'd3) begin bad++; $display("FAIL merge_count_hold got=%0d exp=3", stall_cycle_count); end
  endtask

  task automatic test_branch();
    do_reset();
    cyc(); branch_valid = 1; branch_target = 32'h0000_0100; #1;
    total++; if (register_pc_write_enable !== 1'b1 || register_pc_write_data !== 32'h100) begin
      bad++; $display("FAIL branch_now got we=%b data=%h exp we=1 data=00000100", register_pc_write_enable, register_pc_write_data); end
    cyc(); branch_valid = 0; #1;
    total++; if (register_pc_write_enable !== 1'b0) begin bad++; $display("FAIL branch_after got we=%b exp=0", register_pc_write_enable); end
  endtask

  task automatic test_pending();
    do_reset();
    cyc(); stall_request_mem = 1; branch_valid = 1; branch_target = 32'h200; #1;
    total++; if (register_pc_write_enable !== 1'b0) begin bad++; $display("FAIL pend_stall0 got we=%b exp=0", register_pc_write_enable); end
    cyc(); branch_valid = 0; #1;
    total++; if (register_pc_write_enable !== 1'b0) begin bad++; $display("FAIL pend_stall1 got we=%b exp=0", register_pc_write_enable); end
    cyc(); #1;
    total++; if (register_pc_write_enable !== 1'b0) begin bad++; $display("FAIL pend_stall2 got we=%b exp=0", register_pc_write_enable); end
    cyc(); stall_request_mem = 0; #1;
    total++; if (register_pc_write_enable !== 1'b1 || register_pc_write_data !== 32'h200) begin
      bad++; $display("FAIL pend_issue got we=%b data=%h exp we=1 data=00000200", register_pc_write_enable, register_pc_write_data); end
    total++; if (stall_cycle_count !== 32'd3) begin bad++; $display("FAIL pend_count got=%0d exp=3", stall_cycle_count); end
    cyc(); #1;
    total++; if (register_pc_write_enable !== 1'b0) begin bad++; $display("FAIL pend_cleared got we=%b exp=0", register_pc_write_enable); end
    // Newest stalled branch replaces an older pending one.
    cyc(); stall_request_mem = 1; branch_valid = 1; branch_target = 32'h300;
    cyc(); branch_target = 32'h304;
    cyc(); stall_request_mem = 0; branch_valid = 0; #1;
    total++; if (register_pc_write_enable !== 1'b1 || register_pc_write_data !== 32'h304) begin
      bad++; $display("FAIL pend_newest got we=%b data=%h exp we=1 data=00000304", register_pc_write_enable, register_pc_write_data); end
    // A fresh branch in the unstalled cycle beats the pending one.
    cyc(); stall_request_mem = 1; branch_valid = 1; branch_target = 32'h400;
    cyc(); stall_request_mem = 0; branch_target = 32'h500; #1;
    total++; if (register_pc_write_enable !== 1'b1 || register_pc_write_data !== 32'h500) begin
      bad++; $display("FAIL pend_override got we=%b data=%h exp we=1 data=00000500", register_pc_write_enable, register_pc_write_data); end
    cyc(); branch_valid = 0; #1;
    total++; if (register_pc_write_enable !== 1'b0) begin bad++; $display("FAIL pend_override_clr got we=%b exp=0", register_pc_write_enable); end
  endtask

  task automatic test_exception();
    do_reset();
    cyc(); exception_valid = 1; branch_valid = 1; branch_target = 32'h600; #1;
    total++; if (register_pc_write_enable !== 1'b0 || flush !== 1'b0) begin
      bad++; $display("FAIL exc_commit got we=%b flush=%b exp we=0 flush=0", register_pc_write_enable, flush); end
    cyc(); exception_valid = 0; branch_valid = 0; stall_request_mem = 1; #1;
    total++; if (flush !== 1'b1 || register_pc_write_enable !== 1'b1 || register_pc_write_data !== 32'h20) begin
      bad++; $display("FAIL exc_flush1 got flush=%b we=%b data=%h exp 1 1 00000020", flush, register_pc_write_enable, register_pc_write_data); end
    total++; if (stall !== 6'b0) begin bad++; $display("FAIL exc_stall_forced got=%b exp=000000", stall); end
    cyc(); stall_request_mem = 0; #1;
    total++; if (flush !== 1'b1 || register_pc_write_enable !== 1'b0) begin
      bad++; $display("FAIL exc_flush2 got flush=%b we=%b exp flush=1 we=0", flush, register_pc_write_enable); end
    cyc(); #1;
    total++; if (flush !== 1'b0 || register_pc_write_enable !== 1'b0) begin
      bad++; $display("FAIL exc_done got flush=%b we=%b exp 0 0 (branch dropped)", flush, register_pc_write_enable); end
    total++; if (stall_cycle_count !== 32'd0) begin bad++; $display("FAIL exc_count got=%0d exp=0", stall_cycle_count); end
  endtask

  task automatic test_eret();
    do_reset();
    cyc(); eret_valid = 1; epc = 32'h8000_0040;
    cyc(); eret_valid = 0; #1;
    total++; if (flush !== 1'b1 || register_pc_write_enable !== 1'b1 || register_pc_write_data !== 32'h8000_0040) begin
      bad++; $display("FAIL eret_flush1 got flush=%b we=%b data=%h exp 1 1 80000040", flush, register_pc_write_enable, register_pc_write_data); end
    cyc(); eret_valid = 1; epc = 32'h0000_1234; #1;
    total++; if (flush !== 1'b1 || register_pc_write_enable !== 1'b0) begin
      bad++; $display("FAIL eret_flush2 got flush=%b we=%b exp 1 0", flush, register_pc_write_enable); end
    cyc(); eret_valid = 0; #1;
    total++; if (flush !== 1'b0 || register_pc_write_enable !== 1'b0) begin
      bad++; $display("FAIL eret_ignored got flush=%b we=%b exp 0 0", flush, register_pc_write_enable); end
    // Exception outranks a simultaneous ERET.
    cyc(); exception_valid = 1; eret_valid = 1; epc = 32'h8000_0040;
    cyc(); exception_valid = 0; eret_valid = 0; #1;
    total++; if (register_pc_write_enable !== 1'b1 || register_pc_write_data !== 32'h20) begin
      bad++; $display("FAIL exc_over_eret got we=%b data=%h exp 1 00000020", register_pc_write_enable, register_pc_write_data); end
    cyc(); cyc();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    cyc(); stall_request_id = 1;
    cyc(); stall_request_id = 0; exception_valid = 1;
    cyc(); exception_valid = 0; #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL rmf_inflush got flush=%b exp=1", flush); end
    reset = 0; #1;
    total++; if (flush !== 1'b0 || register_pc_write_enable !== 1'b0 || stall !== 6'b0 || stall_cycle_count !== 32'd0) begin
      bad++; $display("FAIL rmf_cleared got flush=%b we=%b stall=%b count=%0d exp all 0", flush, register_pc_write_enable, stall, stall_cycle_count); end
    cyc(); reset = 1;
    cyc(); #1;
    total++; if (flush !== 1'b0 || register_pc_write_enable !== 1'b0) begin
      bad++; $display("FAIL rmf_run got flush=%b we=%b exp 0 0", flush, register_pc_write_enable); end
    // A pending redirect is discarded by reset.
    cyc(); stall_request_mem = 1; branch_valid = 1; branch_target = 32'h700;
    cyc(); branch_valid = 0; reset = 0; #1;
    cyc(); reset = 1; stall_request_mem = 0; #1;
    total++; if (register_pc_write_enable !== 1'b0) begin bad++; $display("FAIL rmf_pend_drop got we=%b exp=0", register_pc_write_enable); end
  endtask

  initial begin
    test_reset();
    test_stall_merge();
    test_branch();
    test_pending();
    test_exception();
    test_eret();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
